// File: rtl/lstm_cell_update_if.sv
// rtl/lstm_cell_update_if.sv - start/busy/done handshake plus gate and result vectors for lstm_cell_update
interface lstm_cell_update_if #(
    parameter int LAYER_BW = 288
);
    logic                start;
    logic                state_clear;
    logic [LAYER_BW-1:0] gate_z;
    logic [LAYER_BW-1:0] gate_i;
    logic [LAYER_BW-1:0] gate_f;
    logic [LAYER_BW-1:0] gate_o;
    logic                busy;
    logic                done;
    logic [LAYER_BW-1:0] h_out;
    logic [LAYER_BW-1:0] c_out;

    modport master (
        output start, state_clear, gate_z, gate_i, gate_f, gate_o,
        input  busy, done, h_out, c_out
    );

    modport slave (
        input  start, state_clear, gate_z, gate_i, gate_f, gate_o,
        output busy, done, h_out, c_out
    );
endinterface

// File: rtl/lstm_cell_update.sv
// rtl/lstm_cell_update.sv - time-multiplexed LSTM cell-state and output stage (LANES shared multipliers)
// Optional saturating reductions: define LSTM_CELL_SAT_EN.
module lstm_cell_update #(
    parameter int HIDDEN_SZ = 16,
    parameter int QN        = 6,
    parameter int QM        = 11,
    parameter int LANES     = 2
) (
    input  logic              clock,
    input  logic              reset,
    lstm_cell_update_if.slave io
);
    localparam int BITWIDTH = QN + QM + 1;
    localparam int G        = HIDDEN_SZ / LANES;
    localparam int LAYER_BW = BITWIDTH * HIDDEN_SZ;
    localparam int GW       = (G > 1) ? $clog2(G) : 1;
    localparam int PW       = 2 * BITWIDTH;
    localparam logic [GW-1:0] G_LAST = GW'(G - 1);
    localparam logic signed [BITWIDTH-1:0] HT_POS = BITWIDTH'(1 << QM);
    localparam logic signed [BITWIDTH-1:0] HT_NEG = -HT_POS;
`ifdef LSTM_CELL_SAT_EN
    localparam logic signed [PW-1:0] SAT_HI = {{(BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_LO = {{(BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};
`endif

    typedef enum logic [2:0] {IDLE, PH_ZI, PH_CF, PH_OH, COMMIT} state_t;

    state_t                     state_q, state_d;
    logic [GW-1:0]              g_q, g_d;
    logic                       clr_q, clr_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [LAYER_BW-1:0]        z_q, z_d, i_q, i_d, f_q, f_d, o_q, o_d;
    logic [LAYER_BW-1:0]        cn_q, cn_d, hn_q, hn_d;
    logic [LAYER_BW-1:0]        c_state_q, c_state_d, c_out_q, c_out_d, h_out_q, h_out_d;
    logic signed [BITWIDTH-1:0] zi_q [LANES];
    logic signed [BITWIDTH-1:0] zi_d [LANES];
    logic signed [BITWIDTH-1:0] op_a [LANES];
    logic signed [BITWIDTH-1:0] op_b [LANES];
    logic signed [BITWIDTH-1:0] mul_r [LANES];
    logic signed [BITWIDTH-1:0] sum_r [LANES];
    logic signed [PW-1:0]       prod [LANES];
    logic                       accept;

    function automatic logic signed [BITWIDTH-1:0] reduce(input logic signed [PW-1:0] x);
`ifdef LSTM_CELL_SAT_EN
        if (x > SAT_HI)      return SAT_HI[BITWIDTH-1:0];
        else if (x < SAT_LO) return SAT_LO[BITWIDTH-1:0];
        else                 return x[BITWIDTH-1:0];
`else
        return x[BITWIDTH-1:0];
`endif
    endfunction

    function automatic logic signed [BITWIDTH-1:0] hardtanh(input logic signed [BITWIDTH-1:0] x);
        if (x > HT_POS)      return HT_POS;
        else if (x < HT_NEG) return HT_NEG;
        else                 return x;
    endfunction

    function automatic logic signed [BITWIDTH-1:0] elem(input logic [LAYER_BW-1:0] v,
                                                         input logic [GW-1:0] g, input int l);
        return v[(int'(g) * LANES + l) * BITWIDTH +: BITWIDTH];
    endfunction

    // A start coinciding with the done pulse is dropped, not queued.
    assign accept = (state_q == IDLE) && io.start && !done_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = PH_ZI;
            PH_ZI:   state_d = PH_CF;
            PH_CF:   state_d = PH_OH;
            PH_OH:   state_d = (g_q == G_LAST) ? COMMIT : PH_ZI;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Each phase steers a different operand pair into the same lane multipliers.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            op_a[l] = elem(z_q, g_q, l);
            op_b[l] = elem(i_q, g_q, l);
            case (state_q)
                PH_CF: begin
                    op_a[l] = elem(f_q, g_q, l);
                    op_b[l] = clr_q ? '0 : elem(c_state_q, g_q, l);
                end
                PH_OH: begin
                    op_a[l] = elem(o_q, g_q, l);
                    op_b[l] = hardtanh(elem(cn_q, g_q, l));
                end
                default: ;
            endcase
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign prod[l] = op_a[l] * op_b[l];
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            mul_r[l] = reduce(prod[l] >>> QM);
            sum_r[l] = reduce({{BITWIDTH{zi_q[l][BITWIDTH-1]}}, zi_q[l]}
                            + {{BITWIDTH{mul_r[l][BITWIDTH-1]}}, mul_r[l]});
        end
    end

    always_comb begin
        g_d       = g_q;
        clr_d     = clr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        z_d       = z_q;
        i_d       = i_q;
        f_d       = f_q;
        o_d       = o_q;
        cn_d      = cn_q;
        hn_d      = hn_q;
        c_state_d = c_state_q;
        c_out_d   = c_out_q;
        h_out_d   = h_out_q;
        for (int l = 0; l < LANES; l++) zi_d[l] = zi_q[l];
        case (state_q)
            IDLE: if (accept) begin
                z_d    = io.gate_z;
                i_d    = io.gate_i;
                f_d    = io.gate_f;
                o_d    = io.gate_o;
                clr_d  = io.state_clear;
                g_d    = '0;
                busy_d = 1'b1;
            end
            PH_ZI: for (int l = 0; l < LANES; l++) zi_d[l] = mul_r[l];
            PH_CF: for (int l = 0; l < LANES; l++)
                cn_d[(int'(g_q) * LANES + l) * BITWIDTH +: BITWIDTH] = sum_r[l];
            PH_OH: begin
                for (int l = 0; l < LANES; l++)
                    hn_d[(int'(g_q) * LANES + l) * BITWIDTH +: BITWIDTH] = mul_r[l];
                if (g_q != G_LAST) g_d = g_q + GW'(1);
            end
            COMMIT: begin
                c_state_d = cn_q;
                c_out_d   = cn_q;
                h_out_d   = hn_q;
                done_d    = 1'b1;
                busy_d    = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            g_q       <= '0;
            clr_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            z_q       <= '0;
            i_q       <= '0;
            f_q       <= '0;
            o_q       <= '0;
            cn_q      <= '0;
            hn_q      <= '0;
            c_state_q <= '0;
            c_out_q   <= '0;
            h_out_q   <= '0;
            for (int l = 0; l < LANES; l++) zi_q[l] <= '0;
        end else begin
            g_q       <= g_d;
            clr_q     <= clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            z_q       <= z_d;
            i_q       <= i_d;
            f_q       <= f_d;
            o_q       <= o_d;
            cn_q      <= cn_d;
            hn_q      <= hn_d;
            c_state_q <= c_state_d;
            c_out_q   <= c_out_d;
            h_out_q   <= h_out_d;
            for (int l = 0; l < LANES; l++) zi_q[l] <= zi_d[l];
        end
    end

    assign io.busy  = busy_q;
    assign io.done  = done_q;
    assign io.h_out = h_out_q;
    assign io.c_out = c_out_q;
endmodule

// File: tb/tb_lstm_cell_update.sv
// tb/tb_lstm_cell_update.sv - scoreboard bench for lstm_cell_update against an elementwise arithmetic model
module tb_lstm_cell_update;
    localparam int HS = 16, QN = 6, QM = 11, LANES = 2;
    localparam int BW = QN + QM + 1, LBW = BW * HS, LAT = 25;
    localparam longint VMAX = (64'sd1 <<< (BW - 1)) - 1;
    localparam longint VMIN = -(64'sd1 <<< (BW - 1));
    localparam longint ONE = 64'sd1 <<< QM;

    typedef struct {
        logic [LBW-1:0] c;
        logic [LBW-1:0] h;
        int             cap;
    } exp_t;

    logic clock, reset;
    lstm_cell_update_if #(.LAYER_BW(LBW)) io ();
    lstm_cell_update #(.HIDDEN_SZ(HS), .QN(QN), .QM(QM), .LANES(LANES)) dut (
        .clock(clock), .reset(reset), .io(io)
    );

    exp_t   sb[$];
    exp_t   mon_e;
    int     errors = 0, checks = 0, n_issued = 0, n_done = 0, cyc = 0, busy_cnt = 0;
    longint cst[HS];
    int     gz[HS], gi[HS], gf[HS], go[HS];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [LBW-1:0] act, input logic [LBW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference arithmetic on plain integers.
    function automatic longint red(input longint x);
`ifdef LSTM_CELL_SAT_EN
        if (x > VMAX) return VMAX;
        if (x < VMIN) return VMIN;
        return x;
`else
        longint m;
        m = x & ((64'sd1 <<< BW) - 1);
        if (m > VMAX) m = m - (64'sd1 <<< BW);
        return m;
`endif
    endfunction

    function automatic longint mul(input longint a, input longint b);
        return red((a * b) >>> QM);
    endfunction

    function automatic longint ht(input longint x);
        if (x > ONE) return ONE;
        if (x < -ONE) return -ONE;
        return x;
    endfunction

    task automatic model_push(input bit clr);
        exp_t   e;
        longint cp, c, h;
        for (int k = 0; k < HS; k++) begin
            cp = clr ? 0 : cst[k];
            c  = red(mul(gz[k], gi[k]) + mul(gf[k], cp));
            h  = mul(go[k], ht(c));
            cst[k] = c;
            e.c[k*BW +: BW] = c[BW-1:0];
            e.h[k*BW +: BW] = h[BW-1:0];
        end
        e.cap = cyc;
        sb.push_back(e);
        n_issued++;
    endtask

    task automatic set_gates(input int z, input int i, input int f, input int o);
        for (int k = 0; k < HS; k++) begin
            gz[k] = z; gi[k] = i; gf[k] = f; go[k] = o;
        end
    endtask

    task automatic rand_gates(input bit full);
        for (int k = 0; k < HS; k++) begin
            if (full) begin
                gz[k] = int'($urandom_range(0, 262143)) - 131072;
                gi[k] = int'($urandom_range(0, 262143)) - 131072;
                gf[k] = int'($urandom_range(0, 262143)) - 131072;
                go[k] = int'($urandom_range(0, 262143)) - 131072;
            end else begin
                gz[k] = int'($urandom_range(0, 4096)) - 2048;
                gi[k] = int'($urandom_range(0, 2048));
                gf[k] = int'($urandom_range(0, 2048));
                go[k] = int'($urandom_range(0, 2048));
            end
        end
    endtask

    task automatic drive_gates();
        for (int k = 0; k < HS; k++) begin
            io.gate_z[k*BW +: BW] = gz[k][BW-1:0];
            io.gate_i[k*BW +: BW] = gi[k][BW-1:0];
            io.gate_f[k*BW +: BW] = gf[k][BW-1:0];
            io.gate_o[k*BW +: BW] = go[k][BW-1:0];
        end
    endtask

    // Called at a negedge with the DUT idle, or (b2b) at the negedge where done is high.
    task automatic run(input bit clr, input bit b2b);
        int t;
        drive_gates();
        io.state_clear = clr;
        io.start = 1'b1;
        if (b2b) begin
            io.gate_z = ~io.gate_z;
            io.gate_i = ~io.gate_i;
            io.gate_f = ~io.gate_f;
            io.gate_o = ~io.gate_o;
            io.state_clear = ~clr;
            @(negedge clock);
            drive_gates();
            io.state_clear = clr;
        end
        @(posedge clock);
        #1;
        model_push(clr);
        @(negedge clock);
        io.start = 1'b0;
        io.state_clear = 1'($urandom);
        rand_gates(1'b1);
        drive_gates();
        t = 0;
        while (!io.done && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (!io.done) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: no done within %0d cycles of capture", t);
            sb.delete();
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (io.busy) busy_cnt++;
            if (io.done) begin
                n_done++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done seen at cycle %0d, expected none", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chkv("c_out", io.c_out, mon_e.c);
                    chkv("h_out", io.h_out, mon_e.h);
                    chk("latency", cyc - mon_e.cap, LAT);
                    chk("busy_cycles", busy_cnt, LAT);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        io.start = 1'b0;
        io.state_clear = 1'b0;
        io.gate_z = '0; io.gate_i = '0; io.gate_f = '0; io.gate_o = '0;
        for (int k = 0; k < HS; k++) cst[k] = 0;
        #1;
        chk("reset_busy", io.busy, 0);
        chk("reset_done", io.done, 0);
        chkv("reset_h_out", io.h_out, '0);
        chkv("reset_c_out", io.c_out, '0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        set_gates(1024, 1024, 1024, 1024);
        run(1'b1, 1'b0);
        @(negedge clock);
        run(1'b0, 1'b0);
        set_gates(4096, 4096, 0, 2048);
        run(1'b1, 1'b1);
        @(negedge clock);
        set_gates(81920, 81920, 0, 2048);
        run(1'b1, 1'b0);

        // state_clear alone must not touch the held cell state
        @(negedge clock);
        io.state_clear = 1'b1;
        repeat (3) @(negedge clock);
        io.state_clear = 1'b0;
        set_gates(1024, 1024, 1024, 1024);
        run(1'b0, 1'b0);

        // abort: second start at cycle 5 is ignored, reset at cycle 10
        @(negedge clock);
        set_gates(1024, 1024, 1024, 1024);
        drive_gates();
        io.state_clear = 1'b1;
        io.start = 1'b1;
        @(posedge clock);
        #1;
        model_push(1'b1);
        @(negedge clock);
        io.start = 1'b0;
        repeat (4) @(negedge clock);
        rand_gates(1'b1);
        drive_gates();
        io.state_clear = 1'b0;
        io.start = 1'b1;
        @(negedge clock);
        io.start = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_busy", io.busy, 0);
        chk("abort_done", io.done, 0);
        chkv("abort_h_out", io.h_out, '0);
        chkv("abort_c_out", io.c_out, '0);
        sb.delete();
        n_issued--;
        busy_cnt = 0;
        for (int k = 0; k < HS; k++) cst[k] = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        chk("abort_no_done", n_done, n_issued);

        set_gates(1024, 1024, 1024, 1024);
        run(1'b0, 1'b0);
        @(negedge clock);
        run(1'b1, 1'b0);

        for (int r = 0; r < 12; r++) begin
            bit b2b, clr;
            b2b = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 3) == 0);
            rand_gates(1'(r % 2));
            if (!b2b) begin
                @(negedge clock);
                repeat ($urandom_range(0, 3)) @(negedge clock);
            end
            run(clr, b2b);
        end

        repeat (5) @(negedge clock);
        chk("done_count", n_done, n_issued);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lstm_cell_update.md
Name: lstm_cell_update

Overview:
- Parametrised, time-multiplexed LSTM cell-state and output stage.
- Takes activated gate vectors from the gate/nonlinearity front end: z (tanh) and i, f, o (sigmoid).
- Computes c = z*i + f*c_prev and h = o*hardtanh(c) over HIDDEN_SZ elements, using LANES multipliers reused across three phases.
- Owns the cell-state register and uses a start/busy/done handshake. It is the successor to the fixed 16-element, edge-triggered elementwise path.

Parameters:
- HIDDEN_SZ, 16, number of hidden elements; must be a multiple of LANES.
- QN, 6, integer bits of the fixed-point format.
- QM, 11, fractional bits of the fixed-point format.
- LANES, 2, parallel multipliers; elements processed per phase.
- Derived: BITWIDTH = QN+QM+1; G = HIDDEN_SZ/LANES groups; LAYER_BW = BITWIDTH*HIDDEN_SZ.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a computation; accepted only in IDLE.
- state_clear  in  1  sampled with an accepted start; 1 means c_prev is treated as 0 for this computation.
- gate_z  in  LAYER_BW  tanh(z) vector; element k at [k*BITWIDTH +: BITWIDTH], signed.
- gate_i  in  LAYER_BW  sigmoid(i) vector.
- gate_f  in  LAYER_BW  sigmoid(f) vector.
- gate_o  in  LAYER_BW  sigmoid(o) vector.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle pulse; h_out and c_out are updated in the same cycle.
- h_out  out  LAYER_BW  layer output vector; held until the next done.
- c_out  out  LAYER_BW  committed cell-state vector; held until the next done.

Behaviour:
- Reset is asynchronous, active-high, and the only asynchronous path. It clears:
  - state to IDLE;
  - busy, done, h_out and c_out to 0;
  - the cell state c_state to 0.
- Capture: on the rising edge where state=IDLE and start=1:
  - gate_z, gate_i, gate_f and gate_o are registered internally; inputs may change afterwards;
  - state_clear is latched; group counter g=0.
- Start while busy, or while done is high, is ignored with no side effects.
- FSM sequence: IDLE -> PH_ZI -> PH_CF -> PH_OH -> (g<G-1: g++ and back to PH_ZI | g=G-1: COMMIT) -> IDLE. Each state lasts one cycle.
- Element indices handled in group g: k = g*LANES + l, for l in 0..LANES-1.
- PH_ZI: zi[l] <= mul(z[k], i[k]).
- PH_CF: c_next[k] <= add(zi[l], mul(f[k], cp[k])). cp[k] = 0 if the latched clear is set, else c_state[k].
- PH_OH: h_next[k] <= mul(o[k], hardtanh(c_next[k])).
- COMMIT: c_state <= c_next; c_out <= c_next; h_out <= h_next; done=1; busy=0.
- Latency: done is high in the cycle 3*G+1 rising edges after the capture edge (25 for the defaults). Back-to-back throughput is one result per 3*G+2 cycles.
- mul(a,b): full 2*BITWIDTH signed product, arithmetic shift right by QM, then reduced to BITWIDTH by the rule below.
- add(a,b): BITWIDTH+1-bit signed sum, then reduced to BITWIDTH by the rule below.
- Reduction rule: the low BITWIDTH bits are kept (two's-complement wrap), unless the optional feature is compiled in.
- hardtanh(x): clips x to [-(1<<QM), +(1<<QM)]; otherwise passes x unchanged.
- Exactly LANES multiplier instances; the phase muxes select their operands.
- Reset mid-operation aborts the computation: no done, c_state=0, and h_out/c_out are cleared.
- state_clear without an accepted start has no effect.

Optional Feature:
- Macro: LSTM_CELL_SAT_EN.
- Defined: every mul/add reduction saturates to [-(2^(BITWIDTH-1)), 2^(BITWIDTH-1)-1] instead of wrapping.
- Undefined: wrap behaviour as in Behaviour; no saturation logic is synthesised.

Test Plan:
- Reset check: assert reset asynchronously mid-cycle -> busy, done, h_out and c_out read 0 immediately, without waiting for a clock edge.
- Defaults, all gates 1024 (0.5), start with state_clear=1 -> done exactly 25 cycles after the capture edge; every c_out element 512, every h_out element 256; busy high for 25 cycles.
- Repeat the same inputs with state_clear=0 -> c_out 768, h_out 384 per element.
- Clip: z=i=4096, f=0, o=2048, clear=1 -> c_out 8192; hardtanh gives 2048; h_out 2048.
- Overflow: z=i=81920, f=0, o=2048, clear=1:
  - without macro: c_out -131072, h_out -2048;
  - with LSTM_CELL_SAT_EN: c_out 131071, h_out 2048.
- Start pulsed at cycle 5 of a run, then reset at cycle 10 -> the second start is ignored; after reset no done appears; the next cleared run is identical to scenario 2.
